edge_sample_seq: RTL and testbench

//  Sequencer for a DFF sampling datapath. On a start pulse it waits a programmable

---
 rtl/edge_sample_seq.sv | 127 ++++++++++++
 tb/tb_edge_sample_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_sample_seq.sv
// rtl/edge_sample_seq.sv - start/delay/capture/handshake sequencer for a DFF sampling datapath
// Define DUAL_EDGE_EN to also sample i_d on the falling edge, giving two bits per capture cycle.
module edge_sample_seq #(
   parameter int NUM_SAMPLES = 8,
   parameter int DLY_W       = 4
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_start,
   input  logic                               i_abort,
   input  logic [DLY_W-1:0]                   i_dly,
   input  logic                               i_d,
   input  logic                               i_ready,
   output logic                               o_busy,
   output logic                               o_valid,
   output logic [NUM_SAMPLES-1:0]             o_data,
   output logic [$clog2(NUM_SAMPLES+1)-1:0]   o_cnt
);

   localparam int CNT_W = $clog2(NUM_SAMPLES+1);
`ifdef DUAL_EDGE_EN
   localparam int SPC = 2;
`else
   localparam int SPC = 1;
`endif
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(SPC);

   typedef enum logic [1:0] {IDLE, WAIT, CAPT, HOLD} state_t;

   state_t                 state_q;
   logic                   busy_q;
   logic                   valid_q;
   logic [NUM_SAMPLES-1:0] data_q;
   logic [NUM_SAMPLES-1:0] data_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [DLY_W-1:0]       dly_q;

`ifdef DUAL_EDGE_EN
   logic neg_q;

   // Half-cycle sample that becomes the older bit of each captured pair.
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= i_d;
      end
   end

   always_comb begin
      data_d = (data_q << SPC) | NUM_SAMPLES'({neg_q, i_d});
   end
`else
   always_comb begin
      data_d = (data_q << SPC) | NUM_SAMPLES'(i_d);
   end
`endif

   always_comb begin
      cnt_d = CNT_MAX;
      if (cnt_q < CNT_MAX - CNT_STEP) begin
         cnt_d = cnt_q + CNT_STEP;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
      end else if (i_abort) begin
         // Partial capture is left visible on o_data/o_cnt.
         state_q <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  dly_q   <= i_dly;
                  cnt_q   <= '0;
                  data_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (i_dly == '0) ? CAPT : WAIT;
               end
            end
            WAIT: begin
               dly_q <= dly_q - DLY_W'(1);
               if (dly_q == DLY_W'(1)) begin
                  state_q <= CAPT;
               end
            end
            CAPT: begin
               data_q <= data_d;
               cnt_q  <= cnt_d;
               if (cnt_d == CNT_MAX) begin
                  state_q <= HOLD;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (i_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy  = busy_q;
   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_edge_sample_seq.sv
// tb/tb_edge_sample_seq.sv - scoreboard bench for edge_sample_seq
module tb_edge_sample_seq;

   localparam int N  = 8;
   localparam int DW = 4;
   localparam int CW = $clog2(N+1);
`ifdef DUAL_EDGE_EN
   localparam int SPC = 2;
`else
   localparam int SPC = 1;
`endif

   typedef struct {
      logic [N-1:0] data;
      int           cnt;
      int           rise;
      int           hold;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [DW-1:0] dly;
   logic          d;
   logic          ready;
   logic          busy;
   logic          valid;
   logic [N-1:0]  data;
   logic [CW-1:0] cnt;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   xfers    = 0;
   int   xfer_exp = 0;
   int   vld_seen = 0;

   edge_sample_seq #(.NUM_SAMPLES(N), .DLY_W(DW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_abort (abort),
      .i_dly   (dly),
      .i_d     (d),
      .i_ready (ready),
      .o_busy  (busy),
      .o_valid (valid),
      .o_data  (data),
      .o_cnt   (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // rise is the rising edge that first samples o_valid high.
   int   rise_e = 0;
   int   hold_n = 0;
   logic vprev  = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (valid === 1'b1) begin
         vld_seen++;
         if (!vprev) begin
            rise_e = cyc + 1;
            hold_n = 0;
         end
         hold_n++;
         if (ready === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("xfer_data", 32'(data), 32'(e.data));
               chk("xfer_cnt", 32'(cnt), 32'(e.cnt));
               chk("valid_rise_edge", 32'(rise_e), 32'(e.rise));
               chk("valid_hold_cycles", 32'(hold_n), 32'(e.hold));
            end
            xfers++;
         end
      end
      vprev = (valid === 1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int dl, output int s);
      start = 1'b1;
      dly   = DW'(dl);
      step();
      s     = cyc;
      start = 1'b0;
   endtask

   task automatic wait_xfer(input string name);
      int n = 0;
      while (xfers < xfer_exp && n < 60) begin
         step();
         n++;
      end
      chk(name, 32'(xfers), 32'(xfer_exp));
   endtask

   task automatic run(input int dl, input logic [N-1:0] pat, input int ready_lo,
                      input logic [N-1:0] exp_d, input string name);
      int   s;
      exp_t e;
      ready = (ready_lo == 0);
      start_run(dl, s);
      e.data = exp_d;
      e.cnt  = N;
      e.rise = s + dl + N/SPC + 1;
      e.hold = ready_lo + 1;
      sb.push_back(e);
      xfer_exp++;
      for (int j = 1; j <= dl + N/SPC; j++) begin
         if (j > dl) d = pat[N-(j-dl)];
         step();
      end
      repeat (ready_lo) step();
      ready = 1'b1;
      wait_xfer(name);
   endtask

   initial begin : stim
      int s;
      int vld_before;
      rst = 1'b1; start = 1'b0; abort = 1'b0; d = 1'b0; ready = 1'b0; dly = '0;

      repeat (4) begin
         @(negedge clk);
         start = 1'($urandom); abort = 1'($urandom); d = 1'($urandom);
         ready = 1'($urandom); dly = DW'($urandom);
      end
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);

      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0; d = 1'b0; ready = 1'b0; dly = '0;
      rst = 1'b0;
      repeat (10) step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_data", 32'(data), 32'd0);
      chk("idle_cnt", 32'(cnt), 32'd0);

`ifndef DUAL_EDGE_EN
      run(3, 8'hB2, 0, 8'hB2, "basic_done");
      run(1, 8'h5A, 0, 8'h5A, "back_to_back_done");
`endif

      d = 1'b1;
      run(0, 8'hFF, 5, 8'hFF, "backpressure_done");
      step();
      chk("after_hold_busy", 32'(busy), 32'd0);
      chk("after_hold_valid", 32'(valid), 32'd0);

      vld_before = vld_seen;
      start_run(0, s);
      d = 1'b1;
      repeat (3) step();
      chk("abort_pre_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
`ifdef DUAL_EDGE_EN
      chk("abort_cnt", 32'(cnt), 32'd6);
      chk("abort_data", 32'(data), 32'h3F);
`else
      chk("abort_cnt", 32'(cnt), 32'd3);
      chk("abort_data", 32'(data), 32'h07);
`endif
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      repeat (3) step();
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_cnt", 32'(cnt), 32'(3*SPC));
      chk("abort_no_valid", 32'(vld_seen), 32'(vld_before));

      start_run(2, s);
      d = 1'b1;
      repeat (4) step();
      chk("mid_capt_cnt", 32'(cnt), 32'(2*SPC));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_valid", 32'(valid), 32'd0);
      chk("async_rst_data", 32'(data), 32'd0);
      chk("async_rst_cnt", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) step();
      chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef DUAL_EDGE_EN
      begin
         exp_t e;
         ready = 1'b1;
         start_run(0, s);
         e.data = 8'hAA;
         e.cnt  = 8;
         e.rise = s + 5;
         e.hold = 1;
         sb.push_back(e);
         xfer_exp++;
         repeat (4) begin
            d = 1'b1;
            @(negedge clk);
            #1;
            d = 1'b0;
            @(posedge clk);
            #1;
         end
         wait_xfer("dual_edge_done");
      end
`endif

      repeat (3) step();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
